// File: rtl/stage_f.sv
// Fetch stage: owns the PC, fetches over a req/gnt/rvalid handshake and presents
// one instruction at a time to decode, discarding wrong-path responses after redirects.
module stage_f #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] RDD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // State, PC and instruction buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            ibuf_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
        end
    end

    // Next-state logic; a redirect always outranks a stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ibuf_d  = ibuf_q;
        case (state_q)
            S_REQ: begin
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    // A granted request is now wrong-path; its response must be dropped.
                    state_d = imem_gnt ? S_DROP : S_REQ;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid && PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = S_REQ;
                end else if (imem_rvalid) begin
                    ibuf_d  = imem_rdata;
                    state_d = S_READY;
                end else if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_READY: begin
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    state_d = S_REQ;
                end else if (!StallF) begin
                    pc_d    = pc_plus4_s;
                    state_d = S_REQ;
                end else begin
                    state_d = S_READY;
                end
            end
            S_DROP: begin
                if (PCSrcE) begin
                    pc_d = PCTargetE;
                end else begin
                    pc_d = pc_q;
                end
                state_d = imem_rvalid ? S_REQ : S_DROP;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign InstrValidF = (state_q == S_READY);
    assign RDD         = (state_q == S_READY) ? ibuf_q : NOP_INSTR;
    assign PCF         = pc_q;
    assign PCPlus4F    = pc_plus4_s;

endmodule

// File: tb/tb_stage_f.sv
// Directed bench for stage_f: a memory model checks each granted address against an
// expected queue, and a monitor checks every presented instruction against a scoreboard.
module tb_stage_f;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] RDD;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;

    stage_f dut (
        .clk         (clk),
        .rst         (rst),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .RDD         (RDD),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_instr_q[$];
    logic [31:0] exp_addr_q[$];
    int          tests = 0;
    int          fails = 0;

    // memory model state
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          lat = 0;
    int          lat_left = 0;
    int          gnt_hold = 0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives gnt/rvalid for the coming edge; called once per cycle at the falling edge.
    task automatic mem_eval();
        if (!rst) begin
            pend        = 1'b0;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (pend) begin
                if (lat_left == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = ovr_en ? ovr_data : (pend_addr ^ 32'hA5A5_0000);
                    ovr_en      = 1'b0;
                    pend        = 1'b0;
                    chk("rvalid_protocol", {31'd0, imem_req | InstrValidF}, 32'd0);
                end else begin
                    lat_left--;
                end
            end
            imem_gnt = 1'b0;
            if (gnt_hold > 0) begin
                gnt_hold--;
            end else if (imem_req && !pend && !imem_rvalid) begin
                imem_gnt  = 1'b1;
                pend      = 1'b1;
                pend_addr = imem_addr;
                lat_left  = lat;
                if (exp_addr_q.size() == 0) begin
                    chk("grant_unexpected", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    chk("grant_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
        end
    endtask

    task automatic go();
        mem_eval();
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever a new instruction is presented.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (InstrValidF && !prev_valid) begin
                if (exp_instr_q.size() == 0) begin
                    chk("present_unexpected", PCF, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_instr_q.pop_front();
                    chk("mon_RDD", RDD, e.instr);
                    chk("mon_PCF", PCF, e.pc);
                    chk("mon_PCPlus4F", PCPlus4F, e.pc + 32'd4);
                end
            end
            if (!InstrValidF) chk("mon_nop", RDD, NOP);
        end
        prev_valid = InstrValidF;
    end

    initial begin
        rst = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        @(negedge clk);
        go();
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, InstrValidF}, 32'd0);
        chk("rst_RDD", RDD, NOP);
        chk("rst_PCPlus4F", PCPlus4F, 32'd4);

        // zero-wait streaming: 0, 4, 8
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_addr_q.push_back(32'(4 * k));
            exp_instr_q.push_back('{pc: 32'(4 * k), instr: 32'(4 * k) ^ 32'hA5A5_0000});
        end
        for (int i = 1; i <= 8; i++) begin
            go();
            chk("stream_valid", {31'd0, InstrValidF}, {31'd0, (i % 3) == 2});
        end

        // stall in READY at PC 8
        StallF = 1'b1;
        exp_addr_q.push_back(32'd12);
        for (int i = 0; i < 4; i++) begin
            go();
            chk("stall_PCF", PCF, 32'd8);
            chk("stall_RDD", RDD, 32'hA5A5_0008);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        StallF = 1'b0;
        go();
        chk("release_addr", imem_addr, 32'd12);
        chk("release_req", {31'd0, imem_req}, 32'd1);

        // redirect while waiting; late DEADBEEF response is dropped
        lat = 2;
        go();
        PCSrcE = 1'b1; PCTargetE = 32'h100; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        go();
        PCSrcE = 1'b0; lat = 0;
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        go();
        chk("drop_valid", {31'd0, InstrValidF}, 32'd0);
        go();
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_req", {31'd0, imem_req}, 32'd1);

        // redirect coinciding with rvalid in WAIT
        exp_addr_q.push_back(32'h100);
        go();
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        go();
        PCSrcE = 1'b0;
        chk("coinc_req", {31'd0, imem_req}, 32'd1);
        chk("coinc_addr", imem_addr, 32'h200);

        // redirect in READY beats stall
        exp_addr_q.push_back(32'h200);
        exp_instr_q.push_back('{pc: 32'h200, instr: 32'hA5A5_0200});
        go();
        go();
        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h300;
        go();
        StallF = 1'b0; PCSrcE = 1'b0;
        chk("rdy_redir_PCF", PCF, 32'h300);
        chk("rdy_redir_req", {31'd0, imem_req}, 32'd1);

        // no grant for 5 cycles
        gnt_hold = 5;
        for (int i = 0; i < 5; i++) begin
            go();
            chk("nognt_req", {31'd0, imem_req}, 32'd1);
            chk("nognt_valid", {31'd0, InstrValidF}, 32'd0);
            chk("nognt_RDD", RDD, NOP);
        end

        // redirect in REQ without grant, to the wrap boundary
        gnt_hold = 1; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        go();
        PCSrcE = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4F", PCPlus4F, 32'd0);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_instr_q.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h5A5A_FFFC});
        go();
        go();
        go();
        chk("wrap_PCF", PCF, 32'd0);

        // redirect in REQ with grant, then a second redirect while dropping
        exp_addr_q.push_back(32'd0);
        lat = 1; PCSrcE = 1'b1; PCTargetE = 32'h400;
        go();
        chk("reqg_req", {31'd0, imem_req}, 32'd0);
        chk("reqg_PCF", PCF, 32'h400);
        PCTargetE = 32'h500;
        go();
        PCSrcE = 1'b0; lat = 0;
        chk("drop2_PCF", PCF, 32'h500);
        go();
        chk("drop2_addr", imem_addr, 32'h500);
        chk("drop2_req", {31'd0, imem_req}, 32'd1);

        // reset in the middle of WAIT
        exp_addr_q.push_back(32'h500);
        lat = 3;
        go();
        rst = 1'b0;
        go();
        chk("midrst_PCF", PCF, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd1);
        chk("midrst_RDD", RDD, NOP);
        rst = 1'b1; lat = 0;
        exp_addr_q.push_back(32'd0);
        exp_instr_q.push_back('{pc: 32'd0, instr: 32'hA5A5_0000});
        go();
        go();
        chk("midrst_valid", {31'd0, InstrValidF}, 32'd1);
        go();

        chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("instr_q_empty", 32'(exp_instr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
